acc_alu: RTL and testbench
==========================

ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/accumulator width (>=2).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  command present.
REQ-005 SHALL have port: in_ready  out  1  block can accept a command.
REQ-006 SHALL have port: load  in  1  load operand into accumulator (overrides op).
REQ-007 SHALL have port: op  in  3  000 add, 001 sub, 010 mul, 011 div, 100 logic-and, 101 logic-or, 110 bitwise-and, 111 bitwise-or.
REQ-008 SHALL have port: operand  in  WIDTH  second operand (accumulator is first).
REQ-009 SHALL have port: acc  out  WIDTH  accumulator register.
REQ-010 SHALL have port: rem  out  WIDTH  remainder of last successful div.
REQ-011 SHALL have port: out_valid  out  1  one-cycle pulse, result/flags updated.
REQ-012 SHALL have ports: carry, zero, div0  out  1 each  status flags.

Function
REQ-013 SHALL accept a command only on an edge where in_valid && in_ready; in_valid while in_ready=0 is ignored, with no queuing; the requester holds the command.
REQ-014 SHALL implement states IDLE and DIV; in_ready=1 only in IDLE with rst low.
REQ-015 load, add, sub, mul, logic and bitwise ops: acc and flags are updated on the accepting edge, and out_valid=1 for exactly the following cycle; the block stays in IDLE, so back-to-back commands run at one per cycle.
REQ-016 add: {carry,acc} = acc+operand, computed at WIDTH+1 bits.
REQ-017 sub: acc = acc-operand mod 2^WIDTH; carry=1 when operand>acc (borrow).
REQ-018 mul: acc = low WIDTH bits of the product; carry=1 when any upper product bit is nonzero.
REQ-019 logic-and/or: acc = {0..0, (acc!=0) op (operand!=0)}; bitwise ops are per-bit; carry=0.
REQ-020 div with operand!=0: IDLE->DIV on acceptance; restoring division, one quotient bit per cycle, for WIDTH cycles (counter 0..WIDTH-1).
REQ-021 div completion: after the last iteration, acc=quotient, rem=remainder, carry=0, div0=0 on the same edge, then DIV->IDLE.
REQ-022 div latency: out_valid is asserted WIDTH+1 cycles after the accepting edge; in_ready=0 throughout DIV.
REQ-023 div with operand==0: no DIV entry; acc and rem unchanged, div0=1, carry=0, out_valid the next cycle.
REQ-024 div0 is cleared by any other accepted command.
REQ-025 zero SHALL equal (new acc==0) on every update, including load.
REQ-026 load=1: acc=operand, carry=0, and op is ignored.
REQ-027 acc, rem and flags SHALL hold their value between updates.

Reset
REQ-028 rst=1 SHALL on the next edge set acc=0, rem=0, carry=0, zero=1, div0=0, out_valid=0, and state=IDLE; in_ready=0 while rst=1.
REQ-029 rst during DIV SHALL abort the division and discard partial results; no out_valid is produced for the aborted command.
REQ-030 rst SHALL take priority over a simultaneous accept.

Configuration
REQ-031 With macro ACC_ALU_SAT_EN defined, add SHALL saturate to all-ones on overflow and sub SHALL saturate to 0 on borrow; carry still reports the overflow or borrow.
REQ-032 Without ACC_ALU_SAT_EN, add and sub wrap modulo 2^WIDTH; all other ops are unaffected either way.

Verification (WIDTH=8)
REQ-033 reset, load 0x05, add 0x03 -> acc=0x08, carry=0, zero=0, out_valid one cycle after each accept.
REQ-034 load 0xF0, add 0x20 -> acc=0x10, carry=1; with ACC_ALU_SAT_EN -> acc=0xFF, carry=1; then sub 0xFF from 0x10 -> carry=1, acc=0x11 (SAT: 0x00, zero=1).
REQ-035 load 0x64, div 0x07 -> in_ready=0 for 8 cycles, out_valid 9 cycles after accept, acc=0x0E, rem=0x02, in_valid pulses during DIV are ignored.
REQ-036 load 0x33, div 0x00 -> acc=0x33, div0=1, out_valid next cycle; following add 0x01 -> div0=0, acc=0x34.
REQ-037 load 0x10, mul 0x20 -> acc=0x00, carry=1, zero=1; logic-and 0x00 on acc=0x05 -> acc=0x00, zero=1.
REQ-038 start div 0xC8/0x03, assert rst at the 3rd DIV cycle -> acc=0, zero=1, no out_valid, in_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/acc_alu.sv
// acc_alu: accumulator ALU with single-cycle arithmetic/logic ops and a
// multi-cycle restoring divider.
//
// Build option: define ACC_ALU_SAT_EN to make add saturate to all-ones on
// overflow and sub saturate to zero on borrow. carry still reports the
// overflow/borrow. Without it, add and sub wrap modulo 2^WIDTH.
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - command present
//   in_ready  - block can accept a command (IDLE and not in reset)
//   load      - load operand into acc (overrides op)
//   op        - 000 add, 001 sub, 010 mul, 011 div, 100 logic-and,
//               101 logic-or, 110 bitwise-and, 111 bitwise-or
//   operand   - second operand (acc is the first)
//   acc       - accumulator
//   rem       - remainder of the last successful div
//   out_valid - one-cycle pulse when acc/flags have been updated
//   carry     - carry / borrow / multiply overflow
//   zero      - acc == 0 after the last update
//   div0      - last command was a divide by zero
module acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] rem,
  output logic             out_valid,
  output logic             carry,
  output logic             zero,
  output logic             div0
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic             carry_r, carry_s;
  logic             zero_r, zero_s;
  logic             div0_r, div0_s;
  logic             out_valid_r, out_valid_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] quo_r, quo_s;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_r, dvsr_s;
  logic [WIDTH-1:0] prem_r, prem_s; // partial remainder

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   alu_acc_s;
  logic               alu_carry_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH-1:0]   rem_step_s;
  logic [WIDTH-1:0]   quo_step_s;
  logic               qbit_s;
  logic               accept_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign accept_s  = in_valid && in_ready;
  assign acc       = acc_r;
  assign rem       = rem_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign div0      = div0_r;
  assign out_valid = out_valid_r;

  // Single-cycle operation results (div handled separately).
  always_comb begin
    sum_s       = {1'b0, acc_r} + {1'b0, operand};
    prod_s      = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, operand};
    alu_acc_s   = acc_r;
    alu_carry_s = 1'b0;
    case (op)
      3'b000: begin
        alu_carry_s = sum_s[WIDTH];
`ifdef ACC_ALU_SAT_EN
        if (sum_s[WIDTH]) begin
          alu_acc_s = {WIDTH{1'b1}};
        end else begin
          alu_acc_s = sum_s[WIDTH-1:0];
        end
`else
        alu_acc_s = sum_s[WIDTH-1:0];
`endif
      end
      3'b001: begin
        alu_carry_s = (operand > acc_r);
`ifdef ACC_ALU_SAT_EN
        if (operand > acc_r) begin
          alu_acc_s = {WIDTH{1'b0}};
        end else begin
          alu_acc_s = acc_r - operand;
        end
`else
        alu_acc_s = acc_r - operand;
`endif
      end
      3'b010: begin
        alu_acc_s   = prod_s[WIDTH-1:0];
        alu_carry_s = |prod_s[2*WIDTH-1:WIDTH];
      end
      3'b100: alu_acc_s = {{(WIDTH-1){1'b0}}, (|acc_r) & (|operand)};
      3'b101: alu_acc_s = {{(WIDTH-1){1'b0}}, (|acc_r) | (|operand)};
      3'b110: alu_acc_s = acc_r & operand;
      3'b111: alu_acc_s = acc_r | operand;
      default: begin
        alu_acc_s   = acc_r;
        alu_carry_s = 1'b0;
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor if it fits. The difference always fits in WIDTH bits.
  always_comb begin
    rem_shift_s = {prem_r, quo_r[WIDTH-1]};
    if (rem_shift_s >= {1'b0, dvsr_r}) begin
      rem_step_s = rem_shift_s[WIDTH-1:0] - dvsr_r;
      qbit_s     = 1'b1;
    end else begin
      rem_step_s = rem_shift_s[WIDTH-1:0];
      qbit_s     = 1'b0;
    end
    quo_step_s = {quo_r[WIDTH-2:0], qbit_s};
  end

  // Next-state and next-register-value logic.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    rem_s       = rem_r;
    carry_s     = carry_r;
    zero_s      = zero_r;
    div0_s      = div0_r;
    out_valid_s = 1'b0;
    cnt_s       = cnt_r;
    quo_s       = quo_r;
    dvsr_s      = dvsr_r;
    prem_s      = prem_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (load) begin
            acc_s       = operand;
            carry_s     = 1'b0;
            div0_s      = 1'b0;
            zero_s      = (operand == {WIDTH{1'b0}});
            out_valid_s = 1'b1;
          end else if (op == 3'b011) begin
            if (operand == {WIDTH{1'b0}}) begin
              // acc and rem left alone; zero re-evaluated on the unchanged acc
              carry_s     = 1'b0;
              div0_s      = 1'b1;
              zero_s      = (acc_r == {WIDTH{1'b0}});
              out_valid_s = 1'b1;
            end else begin
              state_s = DIV;
              cnt_s   = {CW{1'b0}};
              quo_s   = acc_r;
              dvsr_s  = operand;
              prem_s  = {WIDTH{1'b0}};
            end
          end else begin
            acc_s       = alu_acc_s;
            carry_s     = alu_carry_s;
            div0_s      = 1'b0;
            zero_s      = (alu_acc_s == {WIDTH{1'b0}});
            out_valid_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DIV: begin
        quo_s  = quo_step_s;
        prem_s = rem_step_s;
        cnt_s  = cnt_r + CW'(1'b1);
        if (cnt_r == CNT_LAST) begin
          acc_s       = quo_step_s;
          rem_s       = rem_step_s;
          carry_s     = 1'b0;
          div0_s      = 1'b0;
          zero_s      = (quo_step_s == {WIDTH{1'b0}});
          out_valid_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = DIV;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b1;
      div0_r      <= 1'b0;
      out_valid_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dvsr_r      <= {WIDTH{1'b0}};
      prem_r      <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      rem_r       <= rem_s;
      carry_r     <= carry_s;
      zero_r      <= zero_s;
      div0_r      <= div0_s;
      out_valid_r <= out_valid_s;
      cnt_r       <= cnt_s;
      quo_r       <= quo_s;
      dvsr_r      <= dvsr_s;
      prem_r      <= prem_s;
    end
  end

endmodule

// File: tb/tb_acc_alu.sv
// Scoreboard bench for acc_alu (WIDTH=8): the driver updates a plain
// arithmetic model on each accepted command and queues the expected result;
// a monitor pops and compares whenever out_valid is seen.
module tb_acc_alu;
  localparam int W = 8;
  localparam int unsigned MOD = 32'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         load;
  logic [2:0]   op;
  logic [W-1:0] operand;
  logic [W-1:0] acc;
  logic [W-1:0] rem;
  logic         out_valid;
  logic         carry;
  logic         zero;
  logic         div0;

  acc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .op(op), .operand(operand), .acc(acc), .rem(rem),
    .out_valid(out_valid), .carry(carry), .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] acc;
    logic [W-1:0] rem;
    logic         carry;
    logic         zero;
    logic         div0;
    int           acc_edge;
    bit           lng;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // reference model state (driver side)
  int unsigned m_acc = 0, m_rem = 0;
  bit m_carry = 0, m_div0 = 0;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_rem = 0; m_carry = 0; m_div0 = 0;
  endtask

  task automatic model_cmd(input bit ld, input logic [2:0] o, input int unsigned b, output bit lng);
    int unsigned a, p;
    a = m_acc;
    lng = 0;
    if (ld) begin
      m_acc = b; m_carry = 0; m_div0 = 0;
    end else begin
      m_div0 = 0;
      m_carry = 0;
      case (o)
        3'd0: begin
          m_carry = (a + b) >= MOD;
          m_acc = (a + b) % MOD;
`ifdef ACC_ALU_SAT_EN
          if (m_carry) m_acc = MOD - 1;
`endif
        end
        3'd1: begin
          m_carry = b > a;
          m_acc = (a + MOD - b) % MOD;
`ifdef ACC_ALU_SAT_EN
          if (m_carry) m_acc = 0;
`endif
        end
        3'd2: begin
          p = a * b;
          m_acc = p % MOD;
          m_carry = p >= MOD;
        end
        3'd3: begin
          if (b == 0) m_div0 = 1;
          else begin
            m_acc = a / b; m_rem = a % b; lng = 1;
          end
        end
        3'd4: m_acc = (a != 0 && b != 0) ? 1 : 0;
        3'd5: m_acc = (a != 0 || b != 0) ? 1 : 0;
        3'd6: m_acc = a & b;
        default: m_acc = a | b;
      endcase
    end
  endtask

  // Drive a command at negedge+1 and hold it until it is accepted.
  task automatic issue(input bit ld, input logic [2:0] o, input logic [W-1:0] v);
    int n;
    bit lng;
    exp_t e;
    @(negedge clk); #1;
    in_valid = 1'b1; load = ld; op = o; operand = v;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept within 200 cycles");
      in_valid = 1'b0;
    end else begin
      model_cmd(ld, o, v, lng);
      e.acc = m_acc[W-1:0]; e.rem = m_rem[W-1:0]; e.carry = m_carry;
      e.zero = (m_acc == 0); e.div0 = m_div0; e.acc_edge = cyc + 1; e.lng = lng;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare on out_valid, otherwise verify the outputs hold.
  logic [W-1:0] chk_acc = '0, chk_rem = '0;
  logic chk_carry = 1'b0, chk_zero = 1'b1, chk_div0 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk_acc = '0; chk_rem = '0; chk_carry = 1'b0; chk_zero = 1'b1; chk_div0 = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out_valid actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        check1("acc", acc, e.acc);
        check1("rem", rem, e.rem);
        check1("carry", carry, e.carry);
        check1("zero", zero, e.zero);
        check1("div0", div0, e.div0);
        check1("latency", cyc + 1 - e.acc_edge, e.lng ? W + 1 : 1);
        chk_acc = e.acc; chk_rem = e.rem; chk_carry = e.carry;
        chk_zero = e.zero; chk_div0 = e.div0;
      end
    end else begin
      check1("hold_acc", acc, chk_acc);
      check1("hold_rem", rem, chk_rem);
      check1("hold_flags", {carry, zero, div0}, {chk_carry, chk_zero, chk_div0});
    end
  end

  function automatic logic [W-1:0] rnd_val();
    case ($urandom % 4)
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; load = 1'b0; op = 3'd0; operand = '0;
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 0);
    #1 rst = 1'b0;
    #1;
    check1("rst_acc", acc, 0);
    check1("rst_rem", rem, 0);
    check1("rst_flags", {carry, zero, div0}, 3'b010);
    check1("rst_out_valid", out_valid, 0);
    check1("rst_in_ready_after", in_ready, 1);

    // load 0x05, add 0x03
    issue(1, 3'd0, 8'h05);
    issue(0, 3'd0, 8'h03);
    idle(2);
    check1("add_small", {acc, carry, zero}, {8'h08, 1'b0, 1'b0});

    // overflow add then borrow sub
    issue(1, 3'd0, 8'hF0);
    issue(0, 3'd0, 8'h20);
    idle(2);
`ifdef ACC_ALU_SAT_EN
    check1("add_ovf", {acc, carry}, {8'hFF, 1'b1});
`else
    check1("add_ovf", {acc, carry}, {8'h10, 1'b1});
`endif
    issue(1, 3'd0, 8'h10);
    issue(0, 3'd1, 8'hFF);
    idle(2);
`ifdef ACC_ALU_SAT_EN
    check1("sub_borrow", {acc, carry, zero}, {8'h00, 1'b1, 1'b1});
`else
    check1("sub_borrow", {acc, carry, zero}, {8'h11, 1'b1, 1'b0});
`endif

    // 100 / 7 with ignored in_valid pulses during DIV
    issue(1, 3'd0, 8'h64);
    issue(0, 3'd3, 8'h07);
    for (int i = 0; i < W; i++) begin
      @(negedge clk); #1;
      in_valid = (i % 2 == 0); load = 1'b1; operand = W'($urandom);
      check1("div_busy_in_ready", in_ready, 0);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    check1("div_done_in_ready", in_ready, 1);
    check1("div_result", {acc, rem}, {8'h0E, 8'h02});

    // divide by zero, then clear div0
    issue(1, 3'd0, 8'h33);
    issue(0, 3'd3, 8'h00);
    idle(2);
    check1("div0_set", {acc, div0}, {8'h33, 1'b1});
    issue(0, 3'd0, 8'h01);
    idle(2);
    check1("div0_clear", {acc, div0}, {8'h34, 1'b0});

    // mul overflow, logic-and to zero
    issue(1, 3'd0, 8'h10);
    issue(0, 3'd2, 8'h20);
    idle(2);
    check1("mul_ovf", {acc, carry, zero}, {8'h00, 1'b1, 1'b1});
    issue(1, 3'd0, 8'h05);
    issue(0, 3'd4, 8'h00);
    idle(2);
    check1("land_zero", {acc, zero}, {8'h00, 1'b1});

    // reset in the 3rd DIV cycle aborts the division
    issue(1, 3'd0, 8'hC8);
    issue(0, 3'd3, 8'h03);
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    sbq.delete();
    model_reset();
    #1 check1("abort_in_ready_rst", in_ready, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check1("abort_in_ready", in_ready, 1);
    check1("abort_acc", {acc, zero, out_valid}, {8'h00, 1'b1, 1'b0});
    idle(W + 2);

    // randomized commands with random gaps
    for (int i = 0; i < 300; i++) begin
      issue(($urandom % 5) == 0, 3'($urandom_range(0, 7)), rnd_val());
      if (($urandom % 4) == 0) idle($urandom_range(0, 2));
    end
    idle(W + 4);

    check1("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
